// File: rtl/fc_layer_param.sv
// Parametrised fully-connected layer: per output row, bias plus P-lane MAC over the input
// vector, then shift, optional ReLU and saturation into a signed DW-bit result.
module fc_layer_param #(
   parameter int N_IN   = 128,
   parameter int N_OUT  = 10,
   parameter int DW     = 8,
   parameter int FRAC   = 7,
   parameter int P      = 8,
   parameter int ACC_W  = 24,
   parameter int RELU   = 1,
   parameter int ROM_AW = 11,
   parameter logic [ROM_AW-1:0] W_BASE = '0,
   parameter logic [ROM_AW-1:0] B_BASE = ROM_AW'('h200)
) (
   input  logic                  clk,
   input  logic                  iRst,
   input  logic                  iStart,
   input  logic [N_IN*DW-1:0]    iData,
   input  logic [N_IN*DW-1:0]    data_from_rom,
   output logic [ROM_AW-1:0]     addr_to_rom,
   output logic [N_OUT*DW-1:0]   data_out,
   output logic                  oBusy,
   output logic                  done,
   output logic                  overflow
);

   localparam int MAC_N = N_IN / P;
   localparam int CW    = (MAC_N > 1) ? $clog2(MAC_N) : 1;
   localparam int RW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [CW-1:0] MAC_LAST = CW'(MAC_N - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(N_OUT - 1);
   localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'((1 << (DW - 1)) - 1);
   localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

   typedef enum logic [2:0] {IDLE, B_WAIT, B_GET, W_WAIT, W_GET, MAC, OUT} state_t;

   state_t                    state, state_nxt;
   logic [N_IN*DW-1:0]        x_reg;
   logic [N_IN*DW-1:0]        w_reg;
   logic [N_OUT*DW-1:0]       bias_reg;
   logic signed [ACC_W-1:0]   acc;
   logic [RW-1:0]             row;
   logic [RW-1:0]             row_inc;
   logic [CW-1:0]             mac_cnt;

   logic signed [2*DW-1:0]    prod;
   logic signed [ACC_W-1:0]   mac_sum;
   logic signed [ACC_W-1:0]   y_shift;
   logic signed [ACC_W-1:0]   y_relu;
   logic [DW-1:0]             y_out;
   logic                      sat_hit;
   logic signed [DW-1:0]      bias_sel;

   // Lane j always holds element k+j because x and w are shifted down by P elements per MAC edge.
   always_comb begin
      prod    = '0;
      mac_sum = '0;
      for (int j = 0; j < P; j++) begin
         prod    = (2*DW)'(signed'(x_reg[j*DW +: DW])) * (2*DW)'(signed'(w_reg[j*DW +: DW]));
         mac_sum = mac_sum + ACC_W'(prod);
      end
   end

   always_comb begin
      y_shift = acc >>> FRAC;
      y_relu  = ((RELU != 0) && (y_shift < 0)) ? '0 : y_shift;
      sat_hit = 1'b0;
      y_out   = y_relu[DW-1:0];
      if (y_relu > Y_MAX) begin
         y_out   = {1'b0, {(DW-1){1'b1}}};
         sat_hit = 1'b1;
      end else if (y_relu < Y_MIN) begin
         y_out   = {1'b1, {(DW-1){1'b0}}};
         sat_hit = 1'b1;
      end
   end

   assign bias_sel = signed'(bias_reg[row*DW +: DW]);
   assign row_inc  = row + 1'b1;

   always_ff @(posedge clk or posedge iRst) begin
      if (iRst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (iStart) state_nxt = B_WAIT;
         B_WAIT:  state_nxt = B_GET;
         B_GET:   state_nxt = W_WAIT;
         W_WAIT:  state_nxt = W_GET;
         W_GET:   state_nxt = MAC;
         MAC:     if (mac_cnt == MAC_LAST) state_nxt = OUT;
         OUT:     state_nxt = (row == ROW_LAST) ? IDLE : W_WAIT;
         default: state_nxt = IDLE;
      endcase
   end

   // The input vector rotates rather than shifts so it returns to element 0 for every row.
   always_ff @(posedge clk or posedge iRst) begin
      if (iRst) begin
         x_reg       <= '0;
         w_reg       <= '0;
         bias_reg    <= '0;
         acc         <= '0;
         row         <= '0;
         mac_cnt     <= '0;
         addr_to_rom <= '0;
         data_out    <= '0;
         oBusy       <= 1'b0;
         done        <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (iStart) begin
                  x_reg       <= iData;
                  addr_to_rom <= B_BASE;
                  overflow    <= 1'b0;
                  oBusy       <= 1'b1;
               end
            end
            B_GET: begin
               bias_reg    <= data_from_rom[N_OUT*DW-1:0];
               row         <= '0;
               addr_to_rom <= W_BASE;
            end
            W_GET: begin
               w_reg   <= data_from_rom;
               acc     <= ACC_W'(bias_sel) <<< FRAC;
               mac_cnt <= '0;
            end
            MAC: begin
               acc     <= acc + mac_sum;
               x_reg   <= (x_reg >> (P*DW)) | (x_reg << ((N_IN - P)*DW));
               w_reg   <= w_reg >> (P*DW);
               mac_cnt <= mac_cnt + 1'b1;
            end
            OUT: begin
               data_out[row*DW +: DW] <= y_out;
               if (sat_hit) overflow <= 1'b1;
               if (row == ROW_LAST) begin
                  oBusy <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  row         <= row_inc;
                  addr_to_rom <= W_BASE + ROM_AW'(row_inc);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_layer_param.sv
// Bench for fc_layer_param: ReLU and linear instances side by side, a two-cycle ROM model,
// a table of vectors with a scoreboard, and hand-written timing, start-rule and reset sequences.
module tb_fc_layer_param;

   localparam int N_IN   = 128;
   localparam int N_OUT  = 10;
   localparam int DW     = 8;
   localparam int FRAC   = 7;
   localparam int P      = 8;
   localparam int ROM_AW = 11;
   localparam int R      = N_IN / P + 3;
   localparam int OW     = N_OUT * DW;
   localparam int NVEC   = 8;
   localparam logic [ROM_AW-1:0] W_BASE = 11'h000;
   localparam logic [ROM_AW-1:0] B_BASE = 11'h200;

   typedef struct {
      string      name;
      logic [7:0] xv;
      logic [7:0] wv;
      logic [7:0] b0;
      logic [7:0] bstep;
      bit         useModel;
      logic [7:0] e1;
      logic [7:0] e0;
      logic [7:0] estep;
      bit         ov1;
      bit         ov0;
   } vec_t;

   typedef struct {
      string         name;
      logic [OW-1:0] out1;
      logic [OW-1:0] out0;
      logic          ov1;
      logic          ov0;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 iRst;
   logic                 iStart;
   logic [N_IN*DW-1:0]   iData;
   logic [N_IN*DW-1:0]   rom_q1, rom_q0;
   logic [ROM_AW-1:0]    addr1, addr0;
   logic [OW-1:0]        out1, out0;
   logic                 busy1, busy0, done1, done0, ovf1, ovf0;

   logic [N_IN*DW-1:0]   w_rows [N_OUT];
   logic [N_IN*DW-1:0]   bias_word;
   logic [N_IN*DW-1:0]   x_vec;
   int                   xe [N_IN];
   int                   we [N_OUT][N_IN];
   int                   be [N_OUT];
   vec_t                 tbl [NVEC];
   exp_t                 sb [$];
   int                   tests = 0;
   int                   failed = 0;

   fc_layer_param #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .P(P), .ACC_W(24),
                    .RELU(1), .ROM_AW(ROM_AW), .W_BASE(W_BASE), .B_BASE(B_BASE)) u_relu (
      .clk(clk), .iRst(iRst), .iStart(iStart), .iData(iData), .data_from_rom(rom_q1),
      .addr_to_rom(addr1), .data_out(out1), .oBusy(busy1), .done(done1), .overflow(ovf1));

   fc_layer_param #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .P(P), .ACC_W(24),
                    .RELU(0), .ROM_AW(ROM_AW), .W_BASE(W_BASE), .B_BASE(B_BASE)) u_lin (
      .clk(clk), .iRst(iRst), .iStart(iStart), .iData(iData), .data_from_rom(rom_q0),
      .addr_to_rom(addr0), .data_out(out0), .oBusy(busy0), .done(done0), .overflow(ovf0));

   always #5 clk = ~clk;

   function automatic logic [N_IN*DW-1:0] romWord(input logic [ROM_AW-1:0] a);
      if (a == B_BASE) return bias_word;
      if (a >= W_BASE && int'(a - W_BASE) < N_OUT) return w_rows[int'(a - W_BASE)];
      return '0;
   endfunction

   // One registered stage here plus the DUT's registered address gives the two-edge ROM latency.
   always @(posedge clk) begin
      rom_q1 <= romWord(addr1);
      rom_q0 <= romWord(addr0);
   end

   function automatic vec_t mkVec(input string n, input logic [7:0] xv, input logic [7:0] wv,
                                  input logic [7:0] b0, input logic [7:0] bstep, input bit um,
                                  input logic [7:0] e1, input logic [7:0] e0,
                                  input logic [7:0] estep, input bit ov1, input bit ov0);
      vec_t v;
      v.name = n; v.xv = xv; v.wv = wv; v.b0 = b0; v.bstep = bstep; v.useModel = um;
      v.e1 = e1; v.e0 = e0; v.estep = estep; v.ov1 = ov1; v.ov0 = ov0;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic loadCase(input int idx);
      vec_t       v;
      exp_t       ex;
      logic [7:0] bb;
      int         s, y, y1;
      v = tbl[idx];
      ex.name = v.name;
      ex.out1 = '0; ex.out0 = '0; ex.ov1 = 1'b0; ex.ov0 = 1'b0;
      for (int i = 0; i < N_IN; i++)
         xe[i] = v.useModel ? ((i * 5) % 23) - 11 : int'($signed(v.xv));
      for (int r = 0; r < N_OUT; r++) begin
         bb = v.b0 + 8'(r) * v.bstep;
         be[r] = v.useModel ? r * 7 - 30 : int'($signed(bb));
         for (int i = 0; i < N_IN; i++)
            we[r][i] = v.useModel ? ((i * 3 + r) % 19) - 9 : int'($signed(v.wv));
      end
      bias_word = '0;
      for (int i = 0; i < N_IN; i++) x_vec[i*DW +: DW] = 8'(xe[i]);
      for (int r = 0; r < N_OUT; r++) begin
         bias_word[r*DW +: DW] = 8'(be[r]);
         for (int i = 0; i < N_IN; i++) w_rows[r][i*DW +: DW] = 8'(we[r][i]);
      end
      if (v.useModel) begin
         for (int r = 0; r < N_OUT; r++) begin
            s = be[r] * (1 << FRAC);
            for (int i = 0; i < N_IN; i++) s += xe[i] * we[r][i];
            y  = s >>> FRAC;
            y1 = (y < 0) ? 0 : y;
            if (y1 > 127) begin y1 = 127; ex.ov1 = 1'b1; end
            if (y > 127) begin y = 127; ex.ov0 = 1'b1; end
            else if (y < -128) begin y = -128; ex.ov0 = 1'b1; end
            ex.out1[r*DW +: DW] = 8'(y1);
            ex.out0[r*DW +: DW] = 8'(y);
         end
      end else begin
         for (int r = 0; r < N_OUT; r++) begin
            ex.out1[r*DW +: DW] = v.e1 + 8'(r) * v.estep;
            ex.out0[r*DW +: DW] = v.e0 + 8'(r) * v.estep;
         end
         ex.ov1 = v.ov1;
         ex.ov0 = v.ov0;
      end
      sb.push_back(ex);
   endtask

   task automatic applyStimulus();
      iData  = x_vec;
      iStart = 1'b1;
      @(posedge clk); #1;
      iStart = 1'b0;
   endtask

   // Entered just after the accepting edge (edge 0); follows the run to done and scores it.
   task automatic watchRun(input bit trace, input bit pulses, input bit chain, input int nextIdx);
      int   e;
      bit   busyOk;
      bit   seen;
      exp_t ex;
      busyOk = 1'b1;
      seen   = 1'b0;
      if (trace) checkOutput("addr_bias", OW'(addr1), OW'(B_BASE));
      for (e = 1; e <= 400; e++) begin
         @(posedge clk); #1;
         if (trace)
            for (int r = 0; r < N_OUT; r++)
               if (e == 2 + r * R)
                  checkOutput($sformatf("addr_row%0d", r), OW'(addr1), OW'(W_BASE + ROM_AW'(r)));
         if (done1) begin
            seen = 1'b1;
            break;
         end
         if (!busy1 || !busy0 || done0) busyOk = 1'b0;
         iStart = (pulses && (e == 50 || e == 100)) || (chain && e == 191);
         if (chain && e == 191) iData = ~x_vec;
      end
      if (!seen) e = 401;
      checkOutput("done_edge", OW'(e), OW'(2 + N_OUT * R));
      checkOutput("busy_during_run", OW'(busyOk), OW'(1'b1));
      checkOutput("busy_after_done", OW'({busy1, busy0}), OW'(2'b00));
      checkOutput("done_lin", OW'(done0), OW'(1'b1));
      if (sb.size() == 0) begin
         checkOutput("scoreboard_empty", OW'(sb.size()), OW'(1));
      end else begin
         ex = sb.pop_front();
         checkOutput({ex.name, "_out_relu"}, out1, ex.out1);
         checkOutput({ex.name, "_out_lin"}, out0, ex.out0);
         checkOutput({ex.name, "_ovf_relu"}, OW'(ovf1), OW'(ex.ov1));
         checkOutput({ex.name, "_ovf_lin"}, OW'(ovf0), OW'(ex.ov0));
      end
      if (chain) begin
         loadCase(nextIdx);
         iData  = x_vec;
         iStart = 1'b1;
         @(posedge clk); #1;
         iStart = 1'b0;
      end else begin
         @(posedge clk); #1;
      end
      checkOutput("done_one_cycle", OW'({done1, done0}), OW'(2'b00));
   endtask

   initial begin
      iRst   = 1'b1;
      iStart = 1'b0;
      iData  = '0;
      bias_word = '0;
      for (int r = 0; r < N_OUT; r++) w_rows[r] = '0;
      tbl[0] = mkVec("ones",     8'h01, 8'h01, 8'h00, 8'h01, 1'b0, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0);
      tbl[1] = mkVec("sat",      8'h40, 8'h02, 8'h00, 8'h00, 1'b0, 8'h7F, 8'h7F, 8'h00, 1'b1, 1'b1);
      tbl[2] = mkVec("relu",     8'h01, 8'h00, 8'hF6, 8'h00, 1'b0, 8'h00, 8'hF6, 8'h00, 1'b0, 1'b0);
      tbl[3] = mkVec("negsmall", 8'hFF, 8'h01, 8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0);
      tbl[4] = mkVec("negfull",  8'hC0, 8'h02, 8'h00, 8'h00, 1'b0, 8'h00, 8'h80, 8'h00, 1'b0, 1'b0);
      tbl[5] = mkVec("negsat",   8'hC0, 8'h04, 8'h00, 8'h00, 1'b0, 8'h00, 8'h80, 8'h00, 1'b0, 1'b1);
      tbl[6] = mkVec("possat",   8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 8'h7F, 8'h7F, 8'h00, 1'b1, 1'b1);
      tbl[7] = mkVec("pattern",  8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_data_out", out1 | out0, '0);
      checkOutput("rst_addr", OW'(addr1 | addr0), '0);
      checkOutput("rst_flags", OW'({busy1, busy0, done1, done0, ovf1, ovf0}), '0);
      iRst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < NVEC; i++) begin
         loadCase(i);
         applyStimulus();
         watchRun(i == 0, i == 0, 1'b0, 0);
      end

      // Start in the done cycle is ignored; the one a cycle later starts a fresh run.
      loadCase(1);
      applyStimulus();
      watchRun(1'b0, 1'b0, 1'b1, 0);
      watchRun(1'b1, 1'b0, 1'b0, 0);

      // Asynchronous reset in the middle of row 5's MAC phase, checked before any clock edge.
      loadCase(7);
      applyStimulus();
      repeat (110) @(posedge clk);
      #3;
      iRst = 1'b1;
      #1;
      checkOutput("abort_data_out", out1 | out0, '0);
      checkOutput("abort_addr", OW'(addr1 | addr0), '0);
      checkOutput("abort_flags", OW'({busy1, busy0, done1, done0, ovf1, ovf0}), '0);
      if (sb.size() > 0) void'(sb.pop_front());
      @(posedge clk); #1;
      iRst = 1'b0;
      @(posedge clk); #1;
      loadCase(0);
      applyStimulus();
      watchRun(1'b1, 1'b0, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/fc_layer_param.md
# fc_layer_param

Parametrised fully-connected layer engine, the generalised successor of the fixed 10-output FC stage. It computes out[r] = act(sat((bias[r]·2^FRAC + Σ w[r][i]·x[i]) >>> FRAC)) for r = 0..N_OUT-1 using signed fixed-point Q(DW-FRAC).FRAC arithmetic. Weights and biases are read from the shared weight ROM, one full row per word. Products are accumulated P lanes per cycle, and the block exposes a start/busy/done handshake toward the network sequencer.

## Interface
- N_IN, 128: input vector length; must be divisible by P.
- N_OUT, 10: number of output neurons; must satisfy N_OUT ≤ N_IN.
- DW, 8: element width, signed.
- FRAC, 7: fractional bits of the activation, weight and bias formats.
- P, 8: MAC lanes per cycle.
- ACC_W, 24: accumulator width; must be ≥ 2·DW + clog2(N_IN) + 1.
- RELU, 1: 1 applies ReLU to the output; 0 gives a linear output.
- ROM_AW, 11: ROM address width.
- W_BASE, 11'h000: ROM address of weight row 0. Row r is at W_BASE + r.
- B_BASE, 11'h200: ROM address of the bias word.

- clk  in  1  clock; all state changes on the rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iStart  in  1  single-cycle start request, sampled only in IDLE.
- iData  in  N_IN·DW  input vector; element i is at [i·DW +: DW]; latched on an accepted start.
- data_from_rom  in  N_IN·DW  ROM read word; weight i is at [i·DW +: DW], bias j is at [j·DW +: DW].
- addr_to_rom  out  ROM_AW  ROM read address, registered.
- data_out  out  N_OUT·DW  result vector; element r is at [r·DW +: DW].
- oBusy  out  1  high from an accepted start through the final OUT edge.
- done  out  1  one-cycle pulse on completion.
- overflow  out  1  sticky saturation flag for the current run.

## Operation
- Reset (asynchronous) sets state = IDLE, oBusy = 0, done = 0, overflow = 0, addr_to_rom = 0, data_out = 0, and clears every internal register. Reset mid-run aborts the run completely.
- ROM contract: a read address registered on edge k has its data valid for sampling on edge k+2.
- State sequence:
  - IDLE, on iStart: latch iData, set addr_to_rom = B_BASE, overflow = 0, oBusy = 1, then go to B_WAIT.
  - B_WAIT: go to B_GET.
  - B_GET: latch the bias word, set row = 0, addr_to_rom = W_BASE, then go to W_WAIT.
  - W_WAIT: go to W_GET.
  - W_GET: latch the weight row, set acc = sext(bias[row]) << FRAC, k = 0, then go to MAC.
  - MAC: each edge adds the P products for indices k..k+P-1 to acc, then k += P. After N_IN/P edges, go to OUT.
  - OUT: compute y = acc >>> FRAC (arithmetic shift, floor).
    - If RELU = 1 and y < 0, set y = 0.
    - Clamp y to [−2^(DW−1), 2^(DW−1)−1]. If clamping occurs, set overflow = 1.
    - Write data_out[row] = y.
    - If row = N_OUT−1: set oBusy = 0, done = 1, go to IDLE.
    - Otherwise: row += 1, addr_to_rom = W_BASE + row, go to W_WAIT.
- Arithmetic widths:
  - Products are signed DW×DW giving 2·DW bits, sign-extended to ACC_W.
  - The accumulator cannot wrap when ACC_W meets its minimum.
- Start handling:
  - iStart is ignored outside IDLE.
  - A start asserted in the same cycle as done is ignored, because the state is still OUT.
  - A start in the following IDLE cycle is accepted.
- data_out elements not yet written in the current run keep their previous values. data_out holds its final values until the next run overwrites them.
- overflow holds its value until the next accepted start.

## Timing
- Take edge 0 as the edge that accepts the start.
- addr_to_rom = B_BASE after edge 0.
- The bias word is latched on edge 2.
- Each row takes R = N_IN/P + 3 edges.
- Row r address is issued on edge 2 + r·R, and row r is written on edge 2 + (r+1)·R.
- done is high, and oBusy falls, after edge 2 + N_OUT·R.
  - With defaults: R = 19, completion at edge 192.
- done is high for exactly one cycle.

## Test plan
- Defaults, x[i] = 8'h01, all weights 8'h01, bias[r] = r: acc = (r<<7) + 128, so data_out[r] = r+1 for r = 0..9. overflow = 0, done pulses after edge 192, oBusy is high on edges 1..192.
- Saturation: x[i] = 8'h40, weights 8'h02, bias 0: sum = 16384, and 16384>>7 = 128 saturates, so every output is 8'h7F and overflow = 1.
- ReLU: weights 0, bias 8'hF6: RELU=1 gives out = 8'h00 with overflow = 0. RELU=0 gives out = 8'hF6.
- Address trace: addr_to_rom = 11'h200 after edge 0, then 11'h000 + r after edge 2 + 19r, for r = 0..9.
- Start rules:
  - iStart pulses during MAC are ignored; the trace is unchanged.
  - iStart in the done cycle is ignored.
  - iStart one cycle later is accepted with a new iData; overflow is cleared and results are recomputed.
- Reset asserted asynchronously during row 5 MAC: all outputs go to 0 immediately, with no wait for a clock edge. After release, a fresh start completes with correct results at edge 192.
